// File: rtl/timer_bank_if.sv
// Bus between the CPU execute stage / sound-interrupt logic and the timer bank.
interface timer_bank_if #(
  parameter int NUM_TIMERS = 2,
  parameter int WIDTH      = 8,
  parameter int SEL_W      = 1
);
  logic                  pause;
  logic                  wr_en;
  logic [1:0]            wr_op;
  logic [SEL_W-1:0]      wr_sel;
  logic [WIDTH-1:0]      wr_data;
  logic [SEL_W-1:0]      rd_sel;
  logic [WIDTH-1:0]      rd_data;
  logic [NUM_TIMERS-1:0] active;
  logic [NUM_TIMERS-1:0] expired;
  logic                  tick_out;

  modport master (
    output pause, wr_en, wr_op, wr_sel, wr_data, rd_sel,
    input  rd_data, active, expired, tick_out
  );

  modport slave (
    input  pause, wr_en, wr_op, wr_sel, wr_data, rd_sel,
    output rd_data, active, expired, tick_out
  );
endinterface

// File: rtl/timer_bank.sv
// Bank of down-counting timers driven by a shared prescaler tick, with
// per-channel auto-reload, expiry pulses, global pause and indexed read-back.
module timer_bank #(
  parameter int NUM_TIMERS = 2,
  parameter int WIDTH      = 8,
  parameter int SEL_W      = 1,
  parameter int TICK_DIV   = 1666667,
  parameter int DIV_W      = 21
) (
  input logic         clk,
  input logic         rst,
  timer_bank_if.slave bus
);

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_RELOAD = 2'b01,
    OP_MODE   = 2'b10,
    OP_CLEAR  = 2'b11
  } wr_op_e;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0]      presc_q, presc_d;
  logic                  tick;
  logic                  tick_q;
  logic [WIDTH-1:0]      count_q  [NUM_TIMERS];
  logic [WIDTH-1:0]      count_d  [NUM_TIMERS];
  logic [WIDTH-1:0]      reload_q [NUM_TIMERS];
  logic [WIDTH-1:0]      reload_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] mode_q, mode_d;
  logic [NUM_TIMERS-1:0] expired_q, expired_d;

  always_comb begin
    tick    = (presc_q == DIV_LAST) && !bus.pause;
    presc_d = presc_q;
    if (!bus.pause) begin
      presc_d = (presc_q == DIV_LAST) ? '0 : presc_q + 1'b1;
    end
  end

  // Tick is applied first so that a same-edge load/clear overrides it and
  // cancels its pulse, while reload/mode writes leave the tick on old values.
  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    mode_d    = mode_q;
    expired_d = '0;
    for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
      if (tick && count_q[i] != '0) begin
        if (count_q[i] == WIDTH'(1)) begin
          expired_d[i] = 1'b1;
          count_d[i]   = (mode_q[i] && reload_q[i] != '0) ? reload_q[i] : '0;
        end else begin
          count_d[i] = count_q[i] - 1'b1;
        end
      end
      if (bus.wr_en && bus.wr_sel == SEL_W'(i)) begin
        case (wr_op_e'(bus.wr_op))
          OP_LOAD: begin
            count_d[i]   = bus.wr_data;
            expired_d[i] = 1'b0;
          end
          OP_RELOAD: reload_d[i] = bus.wr_data;
          OP_MODE:   mode_d[i]   = bus.wr_data[0];
          OP_CLEAR: begin
            count_d[i]   = '0;
            expired_d[i] = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      count_q   <= '{default: '0};
      reload_q  <= '{default: '0};
      mode_q    <= '0;
      expired_q <= '0;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick;
      count_q   <= count_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    bus.rd_data  = '0;
    bus.active   = '0;
    bus.expired  = expired_q;
    bus.tick_out = tick_q;
    for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
      bus.active[i] = (count_q[i] != '0);
      if (bus.rd_sel == SEL_W'(i)) begin
        bus.rd_data = count_q[i];
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench: a 3-channel TICK_DIV=4 bank and a 2-channel TICK_DIV=1 bank.
module tb_timer_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timer_bank_if #(.NUM_TIMERS(3), .WIDTH(8), .SEL_W(2)) bus_a ();
  timer_bank_if #(.NUM_TIMERS(2), .WIDTH(8), .SEL_W(1)) bus_b ();

  timer_bank #(
    .NUM_TIMERS(3), .WIDTH(8), .SEL_W(2), .TICK_DIV(4), .DIV_W(2)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  timer_bank #(
    .NUM_TIMERS(2), .WIDTH(8), .SEL_W(1), .TICK_DIV(1), .DIV_W(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int phase = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; tracks the bank-A prescaler phase.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst) phase = 0;
      else if (!bus_a.pause) phase = (phase == 3) ? 0 : phase + 1;
      #1;
    end
  endtask

  // Step until the edge that carries a tick (phase wrapped to 0).
  task automatic next_tick(input string tag);
    for (int k = 0; k < 4; k++) begin
      step(1);
      if (phase == 0) break;
    end
    check(tag, bus_a.tick_out, 1'b1);
  endtask

  // Step until the current cycle is the tick cycle.
  task automatic to_pre_tick();
    for (int k = 0; k < 4; k++) begin
      if (phase == 3) break;
      step(1);
    end
  endtask

  task automatic wr_a(input logic [1:0] op, input logic [1:0] sel, input logic [7:0] data);
    bus_a.wr_op   = op;
    bus_a.wr_sel  = sel;
    bus_a.wr_data = data;
    bus_a.wr_en   = 1'b1;
    step(1);
    bus_a.wr_en   = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    bus_a.rd_sel = sel;
    #1;
    check(tag, bus_a.rd_data, exp);
  endtask

  initial begin
    bus_a.pause = 1'b0; bus_a.wr_en = 1'b0; bus_a.wr_op = 2'b00;
    bus_a.wr_sel = '0;  bus_a.wr_data = '0; bus_a.rd_sel = '0;
    bus_b.pause = 1'b0; bus_b.wr_en = 1'b0; bus_b.wr_op = 2'b00;
    bus_b.wr_sel = '0;  bus_b.wr_data = '0; bus_b.rd_sel = '0;
    step(2);
    check("reset_rd", bus_a.rd_data, 8'h00);
    check("reset_active", bus_a.active, 3'b000);
    rst = 1'b0;

    // TICK_DIV=1 bank: load 4 on a tick edge, then one decrement per cycle
    bus_b.wr_en = 1'b1; bus_b.wr_op = 2'b00; bus_b.wr_sel = 1'b0; bus_b.wr_data = 8'd4;
    step(1);
    bus_b.wr_en = 1'b0;
    check("b_load", bus_b.rd_data, 8'd4);
    check("b_tick_every", bus_b.tick_out, 1'b1);
    check("a_tick_e1", bus_a.tick_out, 1'b0);
    step(1); check("b_cnt3", bus_b.rd_data, 8'd3);
    step(1); check("b_cnt2", bus_b.rd_data, 8'd2);
    check("a_tick_e3", bus_a.tick_out, 1'b0);
    step(1); check("b_cnt1", bus_b.rd_data, 8'd1);
    check("a_first_tick", bus_a.tick_out, 1'b1);
    step(1); check("b_cnt0", bus_b.rd_data, 8'd0);
    check("b_expired", bus_b.expired, 2'b01);
    check("a_tick_drop", bus_a.tick_out, 1'b0);
    step(1); check("b_expired_clr", bus_b.expired, 2'b00);

    // One-shot on channel 2
    wr_a(2'b00, 2'd2, 8'd3);
    rd_a("os_load", 2'd2, 8'd3);
    check("os_active", bus_a.active, 3'b100);
    next_tick("os_t1"); rd_a("os_2", 2'd2, 8'd2);
    next_tick("os_t2"); rd_a("os_1", 2'd2, 8'd1);
    next_tick("os_t3"); rd_a("os_0", 2'd2, 8'd0);
    check("os_expired", bus_a.expired, 3'b100);
    check("os_inactive", bus_a.active, 3'b000);
    step(1);
    check("os_expired_clr", bus_a.expired, 3'b000);
    next_tick("os_t4"); rd_a("os_stay0", 2'd2, 8'd0);
    check("os_no_pulse", bus_a.expired, 3'b000);

    // Auto-reload on channel 0
    wr_a(2'b01, 2'd0, 8'd5);
    wr_a(2'b10, 2'd0, 8'd1);
    wr_a(2'b00, 2'd0, 8'd2);
    next_tick("ar_t1"); rd_a("ar_1", 2'd0, 8'd1);
    next_tick("ar_t2"); rd_a("ar_5", 2'd0, 8'd5);
    check("ar_expired", bus_a.expired, 3'b001);
    step(1);
    check("ar_expired_clr", bus_a.expired, 3'b000);
    next_tick("ar_t3"); rd_a("ar_4", 2'd0, 8'd4);
    wr_a(2'b01, 2'd0, 8'd0);
    next_tick("ar_t4"); rd_a("ar_3", 2'd0, 8'd3);
    next_tick("ar_t5"); rd_a("ar_2b", 2'd0, 8'd2);
    next_tick("ar_t6"); rd_a("ar_1b", 2'd0, 8'd1);
    next_tick("ar_t7"); rd_a("ar_stop0", 2'd0, 8'd0);
    check("ar_stop_expired", bus_a.expired, 3'b001);
    next_tick("ar_t8"); rd_a("ar_stay0", 2'd0, 8'd0);
    check("ar_stay_inactive", bus_a.active[0], 1'b0);

    // Write/tick collisions on channel 1 while channel 0 counts
    wr_a(2'b00, 2'd1, 8'd1);
    wr_a(2'b00, 2'd0, 8'd5);
    to_pre_tick();
    wr_a(2'b00, 2'd1, 8'd9);
    check("col_tick", bus_a.tick_out, 1'b1);
    rd_a("col_load_wins", 2'd1, 8'd9);
    check("col_no_pulse", bus_a.expired, 3'b000);
    rd_a("col_ch0_dec", 2'd0, 8'd4);
    wr_a(2'b00, 2'd1, 8'd1);
    to_pre_tick();
    wr_a(2'b11, 2'd1, 8'd0);
    check("clr_tick", bus_a.tick_out, 1'b1);
    rd_a("clr_wins", 2'd1, 8'd0);
    check("clr_no_pulse", bus_a.expired, 3'b000);
    rd_a("clr_ch0_dec", 2'd0, 8'd3);

    // Pause mid-period: prescaler at 1, frozen for 10 cycles
    step(1);
    bus_a.pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("pause_no_tick", bus_a.tick_out, 1'b0);
    end
    rd_a("pause_hold", 2'd0, 8'd3);
    bus_a.pause = 1'b0;
    step(1); check("resume_c1", bus_a.tick_out, 1'b0);
    step(1); check("resume_c2", bus_a.tick_out, 1'b0);
    step(1); check("resume_tick", bus_a.tick_out, 1'b1);
    rd_a("resume_dec", 2'd0, 8'd2);

    // Out-of-range select, paused so counts are stable
    bus_a.pause = 1'b1;
    wr_a(2'b00, 2'd0, 8'h11);
    wr_a(2'b00, 2'd1, 8'h22);
    wr_a(2'b00, 2'd2, 8'h33);
    wr_a(2'b00, 2'd3, 8'h44);
    wr_a(2'b11, 2'd3, 8'h00);
    wr_a(2'b01, 2'd3, 8'h55);
    wr_a(2'b10, 2'd3, 8'h01);
    rd_a("oor_ch0", 2'd0, 8'h11);
    rd_a("oor_ch1", 2'd1, 8'h22);
    rd_a("oor_ch2", 2'd2, 8'h33);
    rd_a("oor_rd3", 2'd3, 8'h00);
    check("oor_active", bus_a.active, 3'b111);

    // Asynchronous reset mid-run, right after a tick edge
    bus_a.pause = 1'b0;
    next_tick("pre_rst_tick");
    rd_a("pre_rst_ch2", 2'd2, 8'h32);
    rst = 1'b1;
    #1;
    check("arst_rd", bus_a.rd_data, 8'h00);
    check("arst_active", bus_a.active, 3'b000);
    check("arst_expired", bus_a.expired, 3'b000);
    check("arst_tick", bus_a.tick_out, 1'b0);
    check("arst_b_active", bus_b.active, 2'b00);
    step(2);
    rst = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
